// File: rtl/wb_pkg.sv
// wb_sequencer shared types: writeback classes, mux select codes,
// controller states and the class-to-select mapping.
package wb_pkg;

   typedef enum logic [2:0] {
      CLS_ALU     = 3'd0,
      CLS_LOAD    = 3'd1,
      CLS_MFHI    = 3'd2,
      CLS_MFLO    = 3'd3,
      CLS_SLT     = 3'd4,
      CLS_SHIFT   = 3'd5,
      CLS_LUI     = 3'd6,
      CLS_INVALID = 3'd7
   } wb_class_e;

   localparam logic [3:0] SEL_ALU   = 4'd0;
   localparam logic [3:0] SEL_MDR   = 4'd1;
   localparam logic [3:0] SEL_HI    = 4'd2;
   localparam logic [3:0] SEL_LO    = 4'd3;
   localparam logic [3:0] SEL_227   = 4'd4;
   localparam logic [3:0] SEL_ZERO  = 4'd5;
   localparam logic [3:0] SEL_ONE   = 4'd6;
   localparam logic [3:0] SEL_SHIFT = 4'd7;
   localparam logic [3:0] SEL_LUI   = 4'd8;

   typedef enum logic [2:0] {
      ST_INIT_SP,
      ST_IDLE,
      ST_LOAD_WAIT,
      ST_LOAD_CAPT,
      ST_SHIFT_WAIT,
      ST_WRITE
   } wb_state_e;

   // Select for the write-data mux; SLT picks constant 1 or 0.
   function automatic logic [3:0] wb_sel(
      input wb_class_e cls,
      input logic      lt
   );
      logic [3:0] sel;
      sel = SEL_ALU;
      unique case (cls)
         CLS_ALU:   sel = SEL_ALU;
         CLS_LOAD:  sel = SEL_MDR;
         CLS_MFHI:  sel = SEL_HI;
         CLS_MFLO:  sel = SEL_LO;
         CLS_SLT:   sel = lt ? SEL_ONE : SEL_ZERO;
         CLS_SHIFT: sel = SEL_SHIFT;
         CLS_LUI:   sel = SEL_LUI;
         default:   sel = SEL_ALU;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/wb_if.sv
// Writeback request/response bundle between the main control FSM
// (master: wb_req, wb_class, wb_dest, slt_lt, shift_done) and the
// sequencer (slave: mem_to_reg, wb_addr, reg_write, mdr_load, busy, wb_done).
interface wb_if;
   import wb_pkg::*;

   logic       wb_req;
   wb_class_e  wb_class;
   logic [4:0] wb_dest;
   logic       slt_lt;
   logic       shift_done;
   logic [3:0] mem_to_reg;
   logic [4:0] wb_addr;
   logic       reg_write;
   logic       mdr_load;
   logic       busy;
   logic       wb_done;

   modport master (
      output wb_req, wb_class, wb_dest, slt_lt, shift_done,
      input  mem_to_reg, wb_addr, reg_write, mdr_load, busy, wb_done
   );

   modport slave (
      input  wb_req, wb_class, wb_dest, slt_lt, shift_done,
      output mem_to_reg, wb_addr, reg_write, mdr_load, busy, wb_done
   );

endinterface

// File: rtl/wb_wait_cnt.sv
// 4-bit loadable down-counter with zero flag; times the memory read.
// Ports: clk, reset, load/load_val (preset), dec (count down), zero.
module wb_wait_cnt (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/wb_sequencer.sv
// Multicycle register-file writeback controller: stack-pointer init
// write after reset, then one ALU/load/mfhi/mflo/lui/slt/shift writeback
// at a time. Ports: clk, reset, bus (wb_if.slave). All outputs registered.
module wb_sequencer
   import wb_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 2,
   parameter int unsigned SP_REG   = 29
) (
   input  logic clk,
   input  logic reset,
   wb_if.slave  bus
);

   localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT - 1);
   localparam logic [4:0] SP_ADDR = 5'(SP_REG);

   wb_state_e  state_q, state_d;
   logic [3:0] mem_q, mem_d;
   logic [4:0] addr_q, addr_d;
   logic       rw_q, rw_d;
   logic       mdr_q, mdr_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   wb_class_e  cls_q, cls_d;
   logic [4:0] dest_q, dest_d;
   logic       lt_q, lt_d;

   wb_class_e  w_cls;
   logic [4:0] w_dest;
   logic       w_lt;

   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;

   wb_wait_cnt u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (WAIT_LD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      addr_d   = addr_q;
      rw_d     = 1'b0;
      mdr_d    = 1'b0;
      done_d   = 1'b0;
      cls_d    = cls_q;
      dest_d   = dest_q;
      lt_d     = lt_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      w_cls    = cls_q;
      w_dest   = dest_q;
      w_lt     = lt_q;

      unique case (state_q)
         ST_INIT_SP: begin
            rw_d    = 1'b1;
            mem_d   = SEL_227;
            addr_d  = SP_ADDR;
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.wb_req) begin
               // Short classes write straight from the bus values.
               w_cls  = bus.wb_class;
               w_dest = bus.wb_dest;
               w_lt   = bus.slt_lt;
               cls_d  = w_cls;
               dest_d = w_dest;
               lt_d   = w_lt;
               if (w_cls == CLS_LOAD) begin
                  state_d  = ST_LOAD_WAIT;
                  cnt_load = 1'b1;
               end else if (w_cls == CLS_SHIFT) begin
                  state_d = ST_SHIFT_WAIT;
               end else begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_LOAD_WAIT: begin
            if (cnt_zero) begin
               state_d = ST_LOAD_CAPT;
               mdr_d   = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_LOAD_CAPT: begin
            state_d = ST_WRITE;
         end
         ST_SHIFT_WAIT: begin
            if (bus.shift_done) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are loaded on entry so they line up with the state.
      if (state_d == ST_WRITE) begin
         addr_d = w_dest;
         done_d = 1'b1;
         if (w_cls == CLS_INVALID) begin
            mem_d = SEL_ALU;
            rw_d  = 1'b0;
         end else begin
            mem_d = wb_sel(w_cls, w_lt);
            rw_d  = (w_dest != 5'd0);
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT_SP;
         mem_q   <= 4'd0;
         addr_q  <= 5'd0;
         rw_q    <= 1'b0;
         mdr_q   <= 1'b0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         cls_q   <= CLS_ALU;
         dest_q  <= 5'd0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
         addr_q  <= addr_d;
         rw_q    <= rw_d;
         mdr_q   <= mdr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cls_q   <= cls_d;
         dest_q  <= dest_d;
         lt_q    <= lt_d;
      end
   end

   assign bus.mem_to_reg = mem_q;
   assign bus.wb_addr    = addr_q;
   assign bus.reg_write  = rw_q;
   assign bus.mdr_load   = mdr_q;
   assign bus.busy       = busy_q;
   assign bus.wb_done    = done_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed requests plus a
// randomized sweep, checked every cycle against a latency/select model.
module tb_wb_sequencer;
   import wb_pkg::*;

   localparam int MEM_WAIT = 2;

   logic clk;
   logic reset;
   int   asserts;
   int   fails;

   logic [3:0] exp_mem;
   logic [4:0] exp_addr;

   wb_if bus ();

   wb_sequencer #(
      .MEM_WAIT (MEM_WAIT),
      .SP_REG   (29)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string      tag,
      input logic [7:0] obs,
      input logic [7:0] exp_v
   );
      asserts++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_outs(
      input string tag,
      input bit    rw,
      input bit    done,
      input bit    mdr,
      input bit    busy
   );
      chk({tag, ".reg_write"}, 8'(bus.reg_write), 8'(rw));
      chk({tag, ".wb_done"}, 8'(bus.wb_done), 8'(done));
      chk({tag, ".mdr_load"}, 8'(bus.mdr_load), 8'(mdr));
      chk({tag, ".busy"}, 8'(bus.busy), 8'(busy));
      chk({tag, ".mem_to_reg"}, 8'(bus.mem_to_reg), 8'(exp_mem));
      chk({tag, ".wb_addr"}, 8'(bus.wb_addr), 8'(exp_addr));
   endtask

   // Write-data select by class straight from the class table.
   function automatic logic [3:0] exp_sel(input int cls, input bit lt);
      case (cls)
         0: return 4'd0;
         1: return 4'd1;
         2: return 4'd2;
         3: return 4'd3;
         4: return lt ? 4'd6 : 4'd5;
         5: return 4'd7;
         6: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   // Issue one request from IDLE and follow it to the first idle cycle.
   // d: for SHIFT, the cycle after acceptance in which shift_done rises.
   task automatic do_req(
      input string tag,
      input int    cls,
      input int    dest,
      input bit    lt,
      input int    d,
      input bit    noise
   );
      int lat;
      bit ok;
      logic [2:0] c3;
      logic [2:0] rc;
      lat = (cls == 1) ? MEM_WAIT + 2 : (cls == 5) ? d + 1 : 1;
      ok  = (cls != 7) && (dest != 0);
      c3  = 3'(cls);
      chk({tag, ".idle"}, 8'(bus.busy), 8'd0);
      bus.wb_req   = 1'b1;
      bus.wb_class = wb_class_e'(c3);
      bus.wb_dest  = 5'(dest);
      bus.slt_lt   = lt;
      bus.shift_done = (cls == 5) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int t = 1; t <= lat; t++) begin
         step();
         if (t == lat) begin
            exp_mem  = (cls == 7) ? 4'd0 : exp_sel(cls, lt);
            exp_addr = 5'(dest);
         end
         check_outs(tag, ok && (t == lat), t == lat,
                    (cls == 1) && (t == lat - 1), 1'b1);
         bus.wb_req = noise;
         if (noise) begin
            rc = 3'($urandom_range(0, 7));
            bus.wb_class = wb_class_e'(rc);
            bus.wb_dest  = 5'($urandom_range(0, 31));
            bus.slt_lt   = 1'($urandom_range(0, 1));
         end
         if (cls == 5) begin
            bus.shift_done = (t == d);
         end else begin
            bus.shift_done = 1'($urandom_range(0, 1));
         end
      end
      step();
      check_outs({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.wb_req     = 1'b0;
      bus.shift_done = 1'b0;
   endtask

   initial begin
      asserts = 0;
      fails   = 0;
      exp_mem  = 4'd0;
      exp_addr = 5'd0;
      reset          = 1'b1;
      bus.wb_req     = 1'b0;
      bus.wb_class   = CLS_ALU;
      bus.wb_dest    = 5'd0;
      bus.slt_lt     = 1'b0;
      bus.shift_done = 1'b0;

      for (int i = 0; i < 3; i++) begin
         step();
         check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
      end
      reset = 1'b0;
      step();
      exp_mem  = 4'd4;
      exp_addr = 5'd29;
      chk("sp.reg_write", 8'(bus.reg_write), 8'd1);
      chk("sp.mem_to_reg", 8'(bus.mem_to_reg), 8'(exp_mem));
      chk("sp.wb_addr", 8'(bus.wb_addr), 8'(exp_addr));
      chk("sp.wb_done", 8'(bus.wb_done), 8'd0);
      step();
      check_outs("sp.after", 1'b0, 1'b0, 1'b0, 1'b0);

      do_req("alu", 0, 8, 1'b0, 1, 1'b0);
      do_req("load", 1, 9, 1'b0, 1, 1'b1);
      do_req("slt1", 4, 10, 1'b1, 1, 1'b0);
      do_req("slt0", 4, 10, 1'b0, 1, 1'b0);
      do_req("shift", 5, 11, 1'b0, 6, 1'b0);
      do_req("lui0", 6, 0, 1'b0, 1, 1'b0);
      do_req("mfhi", 2, 3, 1'b0, 1, 1'b1);
      do_req("mflo", 3, 31, 1'b0, 1, 1'b0);
      do_req("inval", 7, 5, 1'b1, 1, 1'b0);
      do_req("shift1", 5, 12, 1'b0, 1, 1'b1);

      // Reset during LOAD_WAIT: no capture, no write, sp init again.
      bus.wb_req   = 1'b1;
      bus.wb_class = CLS_LOAD;
      bus.wb_dest  = 5'd9;
      step();
      check_outs("rstld.wait", 1'b0, 1'b0, 1'b0, 1'b1);
      bus.wb_req = 1'b0;
      reset      = 1'b1;
      exp_mem    = 4'd0;
      exp_addr   = 5'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs("rstld.hold", 1'b0, 1'b0, 1'b0, 1'b1);
      end
      reset = 1'b0;
      step();
      exp_mem  = 4'd4;
      exp_addr = 5'd29;
      check_outs("rstld.sp", 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      check_outs("rstld.after", 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         do_req("rand",
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)),
                int'($urandom_range(1, 4)),
                1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, fails);
      $finish;
   end

endmodule
